// File: rtl/serv_pin_bus_sequencer_if.sv
// Bus bundle between SERV's ibus/dbus, the pin nibble bus and the sequencer.
// master = SERV core + pad side, slave = sequencer.
interface serv_pin_bus_sequencer_if;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic [3:0]  i_pin_nib;
  logic        i_pin_valid;
  logic [3:0]  o_pin_nib;
  logic        o_pin_valid;
  logic        o_busy;
  logic        o_err;

  modport master (
    output i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we,
           i_dbus_cyc, i_pin_nib, i_pin_valid,
    input  o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack, o_pin_nib, o_pin_valid,
           o_busy, o_err
  );

  modport slave (
    input  i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we,
           i_dbus_cyc, i_pin_nib, i_pin_valid,
    output o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack, o_pin_nib, o_pin_valid,
           o_busy, o_err
  );
endinterface

// File: rtl/serv_pin_bus_sequencer.sv
// Shares the pin nibble bus between SERV ibus and dbus: one granted request at a time,
// header/address/write-data out as nibbles, read data collected back into a word.
module serv_pin_bus_sequencer #(
  parameter int ADDR_NIBS   = 4,
  parameter int ADDR_LSB    = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  serv_pin_bus_sequencer_if.slave  bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR0 = 3'd1;
  localparam logic [2:0] HDR1 = 3'd2;
  localparam logic [2:0] ADR  = 3'd3;
  localparam logic [2:0] WDAT = 3'd4;
  localparam logic [2:0] RDAT = 3'd5;
  localparam logic [2:0] ACK  = 3'd6;

  localparam int KN = (ADDR_NIBS > 8) ? ADDR_NIBS : 8;
  localparam int KW = $clog2(KN);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [KW-1:0] ADR_LAST = KW'(ADDR_NIBS - 1);
  localparam logic [KW-1:0] DAT_LAST = KW'(7);
  localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit            TO_EN    = (TIMEOUT_CYC > 0);

  logic [2:0]    state;
  logic [KW-1:0] k;
  logic [TW-1:0] idle_cnt;
  logic          grant_d;
  logic          we_q;
  logic          err_q;
  logic [3:0]    sel_q;
  logic [31:0]   adr_sr;
  logic [31:0]   dat_sr;
  logic [31:0]   rd_sr;
  logic [31:0]   rd_next;
  logic [31:0]   ibus_rdt;
  logic [31:0]   dbus_rdt;
  logic [3:0]    pin_nib;
  logic          pin_valid;

  // read nibbles arrive LSB-first, so shift in from the top
  assign rd_next = {bus.i_pin_nib, rd_sr[31:4]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      idle_cnt <= '0;
      grant_d  <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      sel_q    <= '0;
      adr_sr   <= '0;
      dat_sr   <= '0;
      rd_sr    <= '0;
      ibus_rdt <= '0;
      dbus_rdt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.i_dbus_cyc || bus.i_ibus_cyc) begin
          grant_d  <= bus.i_dbus_cyc;
          we_q     <= bus.i_dbus_cyc & bus.i_dbus_we;
          sel_q    <= bus.i_dbus_cyc ? bus.i_dbus_sel : 4'hF;
          adr_sr   <= (bus.i_dbus_cyc ? bus.i_dbus_adr : bus.i_ibus_adr) >> ADDR_LSB;
          dat_sr   <= bus.i_dbus_dat;
          err_q    <= 1'b0;
          idle_cnt <= '0;
          k        <= '0;
          state    <= HDR0;
        end
        HDR0: state <= HDR1;
        HDR1: state <= ADR;
        ADR: begin
          adr_sr <= adr_sr >> 4;
          if (k == ADR_LAST) begin
            k     <= '0;
            state <= we_q ? WDAT : RDAT;
          end else k <= k + 1'b1;
        end
        WDAT: begin
          dat_sr <= dat_sr >> 4;
          if (k == DAT_LAST) begin
            k     <= '0;
            state <= ACK;
          end else k <= k + 1'b1;
        end
        RDAT: begin
          if (bus.i_pin_valid) begin
            rd_sr    <= rd_next;
            idle_cnt <= '0;
            if (k == DAT_LAST) begin
              k     <= '0;
              state <= ACK;
              if (grant_d) dbus_rdt <= rd_next;
              else         ibus_rdt <= rd_next;
            end else k <= k + 1'b1;
          end else if (TO_EN && idle_cnt == TO_LAST) begin
            // abort: hand back all-ones and flag the error on the ack cycle
            k     <= '0;
            err_q <= 1'b1;
            state <= ACK;
            if (grant_d) dbus_rdt <= '1;
            else         ibus_rdt <= '1;
          end else idle_cnt <= idle_cnt + 1'b1;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pin_valid = 1'b0;
    pin_nib   = 4'h0;
    case (state)
      HDR0: begin pin_valid = 1'b1; pin_nib = {we_q, grant_d, 2'b00}; end
      HDR1: begin pin_valid = 1'b1; pin_nib = sel_q;                  end
      ADR:  begin pin_valid = 1'b1; pin_nib = adr_sr[3:0];            end
      WDAT: begin pin_valid = 1'b1; pin_nib = dat_sr[3:0];            end
      default: ;
    endcase
  end

  assign bus.o_pin_valid = pin_valid;
  assign bus.o_pin_nib   = pin_nib;
  assign bus.o_ibus_ack  = (state == ACK) & ~grant_d;
  assign bus.o_dbus_ack  = (state == ACK) &  grant_d;
  assign bus.o_err       = (state == ACK) &  err_q;
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_ibus_rdt  = ibus_rdt;
  assign bus.o_dbus_rdt  = dbus_rdt;

endmodule

// File: tb/tb_serv_pin_bus_sequencer.sv
// Scoreboard bench: expected pin nibbles and acks are queued as requests are issued,
// and a negedge monitor pops and compares them as the sequencer emits them.
module tb_serv_pin_bus_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serv_pin_bus_sequencer_if bus_if();

  serv_pin_bus_sequencer #(.ADDR_NIBS(4), .ADDR_LSB(2), .TIMEOUT_CYC(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  typedef struct {
    bit          dbus;
    logic [31:0] rdt;
    bit          err;
  } ack_t;

  logic [3:0]  pin_q[$];
  ack_t        ack_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_irdt = '0;
  logic [31:0] exp_drdt = '0;
  logic [3:0]  mon_nib;
  ack_t        mon_ack;
  logic [31:0] mon_rdt;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.o_pin_valid) begin
        checks++;
        if (pin_q.size() == 0) begin
          errors++;
          $display("FAIL pin_extra: got nibble %h, none expected", bus_if.o_pin_nib);
        end else begin
          mon_nib = pin_q.pop_front();
          if (bus_if.o_pin_nib !== mon_nib) begin
            errors++;
            $display("FAIL pin_nib: got %h expected %h", bus_if.o_pin_nib, mon_nib);
          end
        end
      end
      if (bus_if.o_ibus_ack || bus_if.o_dbus_ack) begin
        checks++;
        if (ack_q.size() == 0) begin
          errors++;
          $display("FAIL ack_extra: ibus_ack=%b dbus_ack=%b", bus_if.o_ibus_ack, bus_if.o_dbus_ack);
        end else begin
          mon_ack = ack_q.pop_front();
          mon_rdt = mon_ack.dbus ? bus_if.o_dbus_rdt : bus_if.o_ibus_rdt;
          if (bus_if.o_dbus_ack !== mon_ack.dbus || bus_if.o_ibus_ack !== !mon_ack.dbus ||
              mon_rdt !== mon_ack.rdt || bus_if.o_err !== mon_ack.err) begin
            errors++;
            $display("FAIL ack: got dack=%b iack=%b rdt=%h err=%b expected dbus=%b rdt=%h err=%b",
                     bus_if.o_dbus_ack, bus_if.o_ibus_ack, mon_rdt, bus_if.o_err,
                     mon_ack.dbus, mon_ack.rdt, mon_ack.err);
          end
        end
      end else begin
        checks++;
        if (bus_if.o_err !== 1'b0) begin
          errors++;
          $display("FAIL err_stray: got o_err=%b expected 0 outside ack", bus_if.o_err);
        end
      end
    end
  end

  task automatic push_pins(input bit dbus, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input bit we);
    logic [31:0] a;
    a = adr >> 2;
    pin_q.push_back({we & dbus, dbus, 2'b00});
    pin_q.push_back(dbus ? sel : 4'hF);
    for (int i = 0; i < 4; i++) pin_q.push_back(a[4*i +: 4]);
    if (dbus && we)
      for (int i = 0; i < 8; i++) pin_q.push_back(dat[4*i +: 4]);
  endtask

  // Caller is just after a posedge in an IDLE cycle; that cycle is cycle 0.
  task automatic do_txn(input bit dbus, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input bit we, input logic [31:0] rword,
                        input int n_nibs, input int gap, input int drop_at, output int ack_cyc);
    ack_t a;
    int   n, j;
    bit   rd;
    rd = !(dbus && we);
    push_pins(dbus, adr, dat, sel, we);
    a.dbus = dbus;
    a.err  = rd && (n_nibs < 8);
    if (!rd)          a.rdt = exp_drdt;
    else if (a.err)   a.rdt = 32'hFFFF_FFFF;
    else              a.rdt = rword;
    if (rd) begin
      if (dbus) exp_drdt = a.rdt;
      else      exp_irdt = a.rdt;
    end
    ack_q.push_back(a);
    if (dbus) begin
      bus_if.i_dbus_adr = adr; bus_if.i_dbus_dat = dat;
      bus_if.i_dbus_sel = sel; bus_if.i_dbus_we  = we; bus_if.i_dbus_cyc = 1'b1;
    end else begin
      bus_if.i_ibus_adr = adr; bus_if.i_ibus_cyc = 1'b1;
    end
    n = 0;
    ack_cyc = -1;
    while (n < 300) begin
      j = n - 7;
      bus_if.i_pin_nib = 4'($urandom);
      if (rd && j >= 0 && (j % (gap + 1)) == 0 && (j / (gap + 1)) < n_nibs) begin
        bus_if.i_pin_valid = 1'b1;
        bus_if.i_pin_nib   = rword[4*(j/(gap+1)) +: 4];
      end else bus_if.i_pin_valid = (!rd || n < 7);
      if (n == drop_at) begin
        if (dbus) bus_if.i_dbus_cyc = 1'b0;
        else      bus_if.i_ibus_cyc = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (bus_if.o_busy !== (n != 0)) begin
        errors++;
        $display("FAIL busy: cycle %0d got %b expected %b", n, bus_if.o_busy, n != 0);
      end
      if (dbus ? bus_if.o_dbus_ack : bus_if.o_ibus_ack) begin
        ack_cyc = n;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (ack_cyc < 0) begin
      errors++;
      $display("FAIL ack_timeout: got no ack in 300 cycles, expected one");
    end
    @(posedge clk); #1;
    if (dbus) bus_if.i_dbus_cyc = 1'b0;
    else      bus_if.i_ibus_cyc = 1'b0;
    bus_if.i_pin_valid = 1'b0;
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [72:0] outs;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs = {bus_if.o_ibus_rdt, bus_if.o_ibus_ack, bus_if.o_dbus_rdt, bus_if.o_dbus_ack,
            bus_if.o_pin_nib, bus_if.o_pin_valid, bus_if.o_busy, bus_if.o_err};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ibus_fetch();
    int c;
    do_txn(1'b0, 32'h0000_0104, '0, 4'h0, 1'b0, 32'h0000_0073, 8, 0, -1, c);
    chk_int("ibus_fetch_latency", c, 15);
    chk_word("ibus_rdt_held", bus_if.o_ibus_rdt, 32'h0000_0073);
  endtask

  task automatic test_dbus_write();
    int c;
    do_txn(1'b1, 32'h0000_0020, '0, 4'h3, 1'b0, 32'h1234_5678, 8, 0, -1, c);
    chk_int("dbus_read_latency", c, 15);
    do_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, '0, 0, 0, -1, c);
    chk_int("dbus_write_latency", c, 15);
    chk_word("dbus_rdt_kept_on_write", bus_if.o_dbus_rdt, 32'h1234_5678);
    chk_word("ibus_rdt_untouched", bus_if.o_ibus_rdt, 32'h0000_0073);
  endtask

  task automatic test_arbitration();
    int c;
    bus_if.i_ibus_adr = 32'h0000_0200;
    bus_if.i_ibus_cyc = 1'b1;
    do_txn(1'b1, 32'h0000_0044, 32'h0BAD_F00D, 4'h5, 1'b1, '0, 0, 0, -1, c);
    chk_int("arb_dbus_first", c, 15);
    do_txn(1'b0, 32'h0000_0200, '0, 4'h0, 1'b0, 32'hCAFE_0001, 8, 0, -1, c);
    chk_int("arb_ibus_next", c, 15);
  endtask

  task automatic test_read_gaps();
    int c;
    do_txn(1'b1, 32'h0000_0008, '0, 4'hC, 1'b0, 32'h89AB_CDEF, 8, 3, -1, c);
    chk_int("gap_read_latency", c, 36);
    do_txn(1'b0, 32'h0000_0000, '0, 4'h0, 1'b0, 32'h5555_AAAA, 8, 0, 4, c);
    chk_int("cyc_drop_latency", c, 15);
  endtask

  task automatic test_timeout();
    int c;
    do_txn(1'b0, 32'h0000_0300, '0, 4'h0, 1'b0, '0, 0, 0, -1, c);
    chk_int("timeout_none_latency", c, 11);
    do_txn(1'b1, 32'h0000_0304, '0, 4'h1, 1'b0, 32'h0000_0ABC, 3, 0, -1, c);
    chk_int("timeout_partial_latency", c, 14);
    chk_word("timeout_rdt_held", bus_if.o_dbus_rdt, 32'hFFFF_FFFF);
  endtask

  task automatic test_reset_mid();
    int          c;
    logic [72:0] outs;
    push_pins(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1);
    bus_if.i_dbus_adr = 32'h0000_0010; bus_if.i_dbus_dat = 32'hDEAD_BEEF;
    bus_if.i_dbus_sel = 4'hF; bus_if.i_dbus_we = 1'b1; bus_if.i_dbus_cyc = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    outs = {bus_if.o_ibus_rdt, bus_if.o_ibus_ack, bus_if.o_dbus_rdt, bus_if.o_dbus_ack,
            bus_if.o_pin_nib, bus_if.o_pin_valid, bus_if.o_busy, bus_if.o_err};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h expected 0", outs);
    end
    chk_int("reset_mid_nibbles_left", pin_q.size(), 4);
    pin_q.delete();
    bus_if.i_dbus_cyc = 1'b0;
    exp_irdt = '0;
    exp_drdt = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, '0, 0, 0, -1, c);
    chk_int("post_reset_write_latency", c, 15);
    do_txn(1'b0, 32'h0000_0104, '0, 4'h0, 1'b0, 32'h0000_0073, 8, 0, -1, c);
    chk_int("post_reset_fetch_latency", c, 15);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.i_ibus_adr = '0; bus_if.i_ibus_cyc = 1'b0;
    bus_if.i_dbus_adr = '0; bus_if.i_dbus_dat = '0; bus_if.i_dbus_sel = '0;
    bus_if.i_dbus_we  = 1'b0; bus_if.i_dbus_cyc = 1'b0;
    bus_if.i_pin_nib  = '0; bus_if.i_pin_valid = 1'b0;
    test_reset();
    test_ibus_fetch();
    test_dbus_write();
    test_arbitration();
    test_read_gaps();
    test_timeout();
    test_reset_mid();
    repeat (2) @(posedge clk);
    chk_int("pin_queue_drained", pin_q.size(), 0);
    chk_int("ack_queue_drained", ack_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
